// File: rtl/proc_pkg.sv
// Shared constants and types for the instruction fetch path.
package proc_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int          FETCH_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR   = 32'hE1A0_0000;

  typedef enum logic {IDLE, RUN} fetch_state_t;

  // Word-align a byte address.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO with flush; the head entry is always visible on rdata.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= wdata;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, IDLE/RUN control and a 2-deep buffer toward decode.
module fetch_unit
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FETCH_DEPTH + 1);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         push, pop, flush;
  logic [CW-1:0] fifo_count;
  logic         fifo_full, fifo_empty;
  logic [63:0]  fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Redirect wins over everything: flush the buffer and refetch from the target.
  always_comb begin
    pop     = instr_valid && instr_ready;
    flush   = redirect_valid;
    push    = (state_reg == RUN) && !redirect_valid && (!fifo_full || pop);
    pc_next = pc_reg;
    if (redirect_valid)  pc_next = align_pc(redirect_pc);
    else if (push)       pc_next = pc_reg + PC_STEP;
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(FETCH_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({imem_rdata, pc_reg}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign imem_addr   = pc_reg;
  assign instr_valid = (fifo_count != '0) && !fifo_empty;
  assign instr       = fifo_rdata[63:32];
  assign instr_pc    = fifo_rdata[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based fetch model compared every cycle plus literal spot checks.
module tb_fetch_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  logic        m_run;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A00001;
      32'h4:   return 32'hE3A01002;
      32'h8:   return 32'hE0802001;
      32'hC:   return 32'hE0803002;
      default: return NOP_INSTR;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words, refilled from the PC whenever room remains after a pop.
  initial begin
    m_pc = 32'h0;
    m_run = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_pc = 32'h0;
        m_run = 1'b0;
      end else begin
        if (redirect_valid) begin
          mq.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
          if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
          if (m_run && mq.size() < 2) begin
            mq.push_back('{word: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
        m_run = fetch_en;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
      chk("cyc_addr", imem_addr, m_pc);
      if (mq.size() > 0) begin
        chk("cyc_instr", instr, mq[0].word);
        chk("cyc_pc", instr_pc, mq[0].pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] seq_w [5];

  initial begin
    seq_w[0] = 32'hE3A00001; seq_w[1] = 32'hE3A01002; seq_w[2] = 32'hE0802001;
    seq_w[3] = 32'hE0803002; seq_w[4] = 32'hE1A00000;

    // Reset state
    tick(); tick();
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_ipc", instr_pc, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Straight-line stream at full throughput
    fetch_en = 1'b1; instr_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("seq_instr", instr, seq_w[k]);
      chk("seq_pc", instr_pc, 32'(k * 4));
    end

    // Asynchronous reset mid-stream restarts from address 0
    reset_pulse();
    tick(); tick();
    chk("rst_first_instr", instr, 32'hE3A00001);
    chk("rst_first_pc", instr_pc, 32'h0);

    // Decode stalled from start: buffer fills then holds, nothing lost on release
    instr_ready = 1'b0;
    reset_pulse();
    for (int k = 0; k < 5; k++) tick();
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_addr", imem_addr, 32'h8);
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc", instr_pc, 32'(k * 4));
      chk("drain_instr", instr, seq_w[k]);
      tick();
    end

    // Redirect with a full buffer; low address bits ignored
    instr_ready = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000E;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'hC);
    tick();
    chk("redir_instr", instr, 32'hE0803002);
    chk("redir_pc", instr_pc, 32'hC);

    // PC wraps modulo 2^32
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'hE1A00000);

    // fetch_en low with two buffered entries: drain, PC frozen
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    fetch_en = 1'b0;
    tick();
    chk("idle_addr0", imem_addr, 32'h8);
    chk("idle_pc0", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    chk("idle_pc1", instr_pc, 32'h4);
    chk("idle_addr1", imem_addr, 32'h8);
    tick();
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_addr2", imem_addr, 32'h8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
